// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl -- commit-stage trap / return / wait-for-interrupt controller.
//
// Decides, per committed instruction, whether it retires normally, takes a
// trap (interrupt or exception), returns from a trap (MRET) or parks the core
// (WFI). Traps and returns redirect fetch through a valid/ready handshake.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   commit_valid/ready  commit-stage instruction handshake
//   commit_pc           PC of the commit-stage instruction
//   commit_exc/cause    exception raised by it and its cause code
//   commit_mret/wfi     the instruction is MRET / WFI
//   interrupted         enabled interrupt pending (CSR file)
//   trap_pc, ret_pc     mtvec / mepc (CSR file)
//   handle_trap         trap-entry strobe to the CSR file
//   exit_trap           trap-return strobe to the CSR file
//   exception           the trap is an exception (0 for interrupts)
//   exception_cause     cause code for the CSR file (0 unless exception)
//   current_pc          PC saved as mepc (0 unless handle_trap)
//   redirect_valid/     fetch redirect handshake; redirect_pc is held
//   ready/pc              stable while redirect_valid is high
//   flush               kill all younger in-flight instructions
//   retired             one pulse per architecturally retired instruction
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are 1. commit_ready does not depend on commit_valid, and
// redirect_valid/redirect_pc do not depend on redirect_ready.
//
// Event strobes are decoded in the event cycle (from state plus the commit
// inputs) so a trap is visible at T and the redirect at T+1; commit_ready
// and redirect_valid are decoded from the state register only.
// ---------------------------------------------------------------------------
module trap_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        commit_valid,
  output logic        commit_ready,
  input  logic [31:0] commit_pc,
  input  logic        commit_exc,
  input  logic [30:0] commit_cause,
  input  logic        commit_mret,
  input  logic        commit_wfi,
  input  logic        interrupted,
  input  logic [31:0] trap_pc,
  input  logic [31:0] ret_pc,
  output logic        handle_trap,
  output logic        exit_trap,
  output logic        exception,
  output logic [30:0] exception_cause,
  output logic [31:0] current_pc,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        retired
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    WFI      = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] redirect_pc_q;
  logic [31:0] wake_pc_q;

  // Prioritised commit events: interrupt > exception > mret > wfi > normal.
  // An interrupt is only taken against a valid instruction so it has a PC.
  logic take_irq, take_exc, take_mret, take_wfi, take_norm;

  always_comb begin
    take_irq  = commit_valid & interrupted;
    take_exc  = commit_valid & ~interrupted & commit_exc;
    take_mret = commit_valid & ~interrupted & ~commit_exc & commit_mret;
    take_wfi  = commit_valid & ~interrupted & ~commit_exc & ~commit_mret & commit_wfi;
    take_norm = commit_valid & ~interrupted & ~commit_exc & ~commit_mret & ~commit_wfi;
  end

  // Output decode; everything is forced low while reset is asserted so no
  // strobe can escape during reset regardless of the current state.
  always_comb begin
    commit_ready    = 1'b0;
    redirect_valid  = 1'b0;
    handle_trap     = 1'b0;
    exit_trap       = 1'b0;
    exception       = 1'b0;
    exception_cause = '0;
    current_pc      = '0;
    flush           = 1'b0;
    retired         = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          commit_ready = 1'b1;
          if (take_irq) begin
            handle_trap = 1'b1;
            current_pc  = commit_pc;
            flush       = 1'b1;
          end else if (take_exc) begin
            handle_trap     = 1'b1;
            exception       = 1'b1;
            exception_cause = commit_cause;
            current_pc      = commit_pc;
            flush           = 1'b1;
          end else if (take_mret) begin
            exit_trap = 1'b1;
            retired   = 1'b1;
            flush     = 1'b1;
          end else if (take_wfi) begin
            retired = 1'b1;
            flush   = 1'b1;
          end else if (take_norm) begin
            retired = 1'b1;
          end
        end
        REDIRECT: begin
          redirect_valid = 1'b1;
          flush          = 1'b1;
        end
        WFI: begin
          flush = 1'b1;
          if (interrupted) begin
            handle_trap = 1'b1;
            current_pc  = wake_pc_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign redirect_pc = redirect_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      redirect_pc_q <= '0;
      wake_pc_q     <= '0;
    end else begin
      case (state)
        RUN: begin
          if (take_irq || take_exc) begin
            redirect_pc_q <= trap_pc;
            state         <= REDIRECT;
          end else if (take_mret) begin
            redirect_pc_q <= ret_pc;
            state         <= REDIRECT;
          end else if (take_wfi) begin
            // Resume point after the WFI; wraps naturally at 2^32.
            wake_pc_q <= commit_pc + 32'd4;
            state     <= WFI;
          end
        end
        REDIRECT: begin
          if (redirect_ready) state <= RUN;
        end
        WFI: begin
          if (interrupted) begin
            redirect_pc_q <= trap_pc;
            state         <= REDIRECT;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl -- self-checking bench for trap_ctrl: directed scenarios plus
// a randomized run against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        commit_valid = 1'b0;
  logic        commit_ready;
  logic [31:0] commit_pc = '0;
  logic        commit_exc = 1'b0;
  logic [30:0] commit_cause = '0;
  logic        commit_mret = 1'b0;
  logic        commit_wfi = 1'b0;
  logic        interrupted = 1'b0;
  logic [31:0] trap_pc = '0;
  logic [31:0] ret_pc = '0;
  logic        handle_trap, exit_trap, exception;
  logic [30:0] exception_cause;
  logic [31:0] current_pc;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        flush, retired;

  int total = 0;
  int bad = 0;

  trap_ctrl dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_exc(commit_exc), .commit_cause(commit_cause),
    .commit_mret(commit_mret), .commit_wfi(commit_wfi),
    .interrupted(interrupted), .trap_pc(trap_pc), .ret_pc(ret_pc),
    .handle_trap(handle_trap), .exit_trap(exit_trap), .exception(exception),
    .exception_cause(exception_cause), .current_pc(current_pc),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush), .retired(retired)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    commit_valid   = 1'b0;
    commit_pc      = '0;
    commit_exc     = 1'b0;
    commit_cause   = '0;
    commit_mret    = 1'b0;
    commit_wfi     = 1'b0;
    interrupted    = 1'b0;
    redirect_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    commit_valid = 1'b1; commit_exc = 1'b1; interrupted = 1'b1; commit_pc = 32'h10;
    #1;
    total++; if ({handle_trap, exit_trap, exception, retired, flush, redirect_valid} !== 6'b0) begin
      bad++; $display("FAIL reset_strobes: got %b want 000000", {handle_trap, exit_trap, exception, retired, flush, redirect_valid}); end
    @(negedge clk);
    reset = 1'b0; drive_idle();
    #1;
    total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", commit_ready); end
    total++; if (redirect_pc !== 32'h0) begin bad++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
    total++; if (redirect_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %b want 0", redirect_valid); end
  endtask

  task automatic test_exception();
    @(negedge clk);
    drive_idle();
    commit_valid = 1'b1; commit_exc = 1'b1; commit_cause = 31'd2; commit_pc = 32'h100; trap_pc = 32'h80;
    #1;
    total++; if ({handle_trap, exception, exit_trap, retired, flush} !== 5'b11001) begin
      bad++; $display("FAIL exc_strobes: got %b want 11001", {handle_trap, exception, exit_trap, retired, flush}); end
    total++; if (exception_cause !== 31'd2) begin bad++; $display("FAIL exc_cause: got %0d want 2", exception_cause); end
    total++; if (current_pc !== 32'h100) begin bad++; $display("FAIL exc_pc: got %h want 100", current_pc); end
    @(negedge clk);
    drive_idle(); trap_pc = 32'h0; redirect_ready = 1'b1;
    #1;
    total++; if ({redirect_valid, commit_ready, handle_trap, flush} !== 4'b1001) begin
      bad++; $display("FAIL exc_redirect: got %b want 1001", {redirect_valid, commit_ready, handle_trap, flush}); end
    total++; if (redirect_pc !== 32'h80) begin bad++; $display("FAIL exc_rpc: got %h want 80", redirect_pc); end
    @(negedge clk);
    redirect_ready = 1'b0;
    #1;
    total++; if ({commit_ready, redirect_valid} !== 2'b10) begin
      bad++; $display("FAIL exc_resume: got %b want 10", {commit_ready, redirect_valid}); end
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    drive_idle();
    commit_valid = 1'b1; interrupted = 1'b1; commit_exc = 1'b1; commit_cause = 31'd5;
    commit_pc = 32'h200; trap_pc = 32'h90;
    #1;
    total++; if ({handle_trap, exception, retired} !== 3'b100) begin
      bad++; $display("FAIL sim_strobes: got %b want 100", {handle_trap, exception, retired}); end
    total++; if (current_pc !== 32'h200) begin bad++; $display("FAIL sim_pc: got %h want 200", current_pc); end
    total++; if (exception_cause !== 31'd0) begin bad++; $display("FAIL sim_cause: got %0d want 0", exception_cause); end
    @(negedge clk);
    drive_idle(); interrupted = 1'b1; commit_valid = 1'b1; redirect_ready = 1'b1;
    #1;
    total++; if ({redirect_valid, handle_trap} !== 2'b10) begin
      bad++; $display("FAIL sim_ignore: got %b want 10", {redirect_valid, handle_trap}); end
    total++; if (redirect_pc !== 32'h90) begin bad++; $display("FAIL sim_rpc: got %h want 90", redirect_pc); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_mret();
    int n_rv;
    int n_exit;
    @(negedge clk);
    drive_idle();
    commit_valid = 1'b1; commit_mret = 1'b1; commit_pc = 32'h60; ret_pc = 32'h204;
    #1;
    total++; if ({exit_trap, handle_trap, retired, flush} !== 4'b1011) begin
      bad++; $display("FAIL mret_strobes: got %b want 1011", {exit_trap, handle_trap, retired, flush}); end
    n_exit = int'(exit_trap);
    n_rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_idle(); ret_pc = 32'h0; redirect_ready = (i == 3);
      #1;
      n_rv += int'(redirect_valid);
      n_exit += int'(exit_trap);
      total++; if (redirect_pc !== 32'h204) begin bad++; $display("FAIL mret_rpc%0d: got %h want 204", i, redirect_pc); end
      total++; if (commit_ready !== 1'b0) begin bad++; $display("FAIL mret_ready%0d: got %b want 0", i, commit_ready); end
    end
    @(negedge clk);
    drive_idle();
    #1;
    total++; if ({commit_ready, redirect_valid} !== 2'b10) begin
      bad++; $display("FAIL mret_resume: got %b want 10", {commit_ready, redirect_valid}); end
    total++; if (n_rv !== 4) begin bad++; $display("FAIL mret_rv_cycles: got %0d want 4", n_rv); end
    total++; if (n_exit !== 1) begin bad++; $display("FAIL mret_exit_pulses: got %0d want 1", n_exit); end
  endtask

  task automatic test_wfi(input logic [31:0] pc, input logic [31:0] exp_wake);
    @(negedge clk);
    drive_idle();
    commit_valid = 1'b1; commit_wfi = 1'b1; commit_pc = pc;
    #1;
    total++; if ({retired, flush, handle_trap} !== 3'b110) begin
      bad++; $display("FAIL wfi_strobes: got %b want 110", {retired, flush, handle_trap}); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_idle(); commit_valid = 1'b1; commit_pc = 32'h1234;
      #1;
      total++; if ({commit_ready, flush, handle_trap, retired} !== 4'b0100) begin
        bad++; $display("FAIL wfi_wait%0d: got %b want 0100", i, {commit_ready, flush, handle_trap, retired}); end
    end
    @(negedge clk);
    drive_idle(); interrupted = 1'b1; trap_pc = 32'h80;
    #1;
    total++; if ({handle_trap, exception} !== 2'b10) begin
      bad++; $display("FAIL wfi_wake: got %b want 10", {handle_trap, exception}); end
    total++; if (current_pc !== exp_wake) begin bad++; $display("FAIL wfi_pc: got %h want %h", current_pc, exp_wake); end
    @(negedge clk);
    drive_idle(); redirect_ready = 1'b1;
    #1;
    total++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h80) begin
      bad++; $display("FAIL wfi_redirect: got %b/%h want 1/80", redirect_valid, redirect_pc); end
    @(negedge clk);
    drive_idle();
    #1;
    total++; if (commit_ready !== 1'b1) begin bad++; $display("FAIL wfi_resume: got %b want 1", commit_ready); end
  endtask

  task automatic test_irq_no_valid();
    @(negedge clk);
    drive_idle(); interrupted = 1'b1; trap_pc = 32'hA0;
    #1;
    total++; if ({handle_trap, commit_ready, flush} !== 3'b010) begin
      bad++; $display("FAIL irq_novalid: got %b want 010", {handle_trap, commit_ready, flush}); end
    @(negedge clk);
    commit_valid = 1'b1; commit_pc = 32'h400;
    #1;
    total++; if (handle_trap !== 1'b1 || current_pc !== 32'h400) begin
      bad++; $display("FAIL irq_taken: got %b/%h want 1/400", handle_trap, current_pc); end
    @(negedge clk);
    drive_idle(); redirect_ready = 1'b1;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive_idle(); commit_valid = 1'b1; commit_pc = 32'h1000 + 32'(4 * i);
      #1;
      total++; if ({retired, flush, commit_ready, handle_trap} !== 4'b1010) begin
        bad++; $display("FAIL b2b%0d: got %b want 1010", i, {retired, flush, commit_ready, handle_trap}); end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_idle(); commit_valid = 1'b1; commit_exc = 1'b1; commit_pc = 32'h700; trap_pc = 32'hC0;
    @(negedge clk);
    drive_idle(); reset = 1'b1;
    #1;
    total++; if ({redirect_valid, flush, handle_trap} !== 3'b000) begin
      bad++; $display("FAIL rmid_during: got %b want 000", {redirect_valid, flush, handle_trap}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({redirect_valid, commit_ready} !== 2'b01 || redirect_pc !== 32'h0) begin
      bad++; $display("FAIL rmid_after: got %b/%h want 01/0", {redirect_valid, commit_ready}, redirect_pc); end
    // reset while parked in WFI: the core must come back running, not asleep
    @(negedge clk);
    drive_idle(); commit_valid = 1'b1; commit_wfi = 1'b1; commit_pc = 32'h500;
    @(negedge clk);
    drive_idle(); reset = 1'b1; interrupted = 1'b1;
    #1;
    total++; if (handle_trap !== 1'b0) begin bad++; $display("FAIL rwfi_during: got %b want 0", handle_trap); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if ({commit_ready, handle_trap, flush} !== 3'b100) begin
      bad++; $display("FAIL rwfi_after: got %b want 100", {commit_ready, handle_trap, flush}); end
    @(negedge clk);
    drive_idle();
  endtask

  // ---------------- randomized run against a behavioural model ----------------
  // The model tracks what the core is doing (running, waiting for fetch to
  // accept a new target, or sleeping until an interrupt) and derives every
  // output from the architectural rules.
  localparam int M_RUNNING = 0, M_TARGET = 1, M_ASLEEP = 2;

  task automatic test_random();
    int          mode;
    logic [31:0] target, wake;
    logic [101:0] exp_v, got_v;
    logic        e_ready, e_ht, e_et, e_exc, e_fl, e_ret, e_rv;
    logic [30:0] e_cause;
    logic [31:0] e_cpc;
    do_reset();
    mode = M_RUNNING; target = '0; wake = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset          = ($urandom_range(0, 99) < 2);
      commit_valid   = ($urandom_range(0, 99) < 60);
      interrupted    = ($urandom_range(0, 99) < 8);
      commit_exc     = ($urandom_range(0, 99) < 10);
      commit_mret    = ($urandom_range(0, 99) < 10);
      commit_wfi     = ($urandom_range(0, 99) < 10);
      redirect_ready = ($urandom_range(0, 99) < 50);
      commit_cause   = 31'($urandom);
      commit_pc      = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      trap_pc        = $urandom;
      ret_pc         = $urandom;
      #1;
      {e_ready, e_ht, e_et, e_exc, e_fl, e_ret, e_rv} = '0;
      e_cause = '0; e_cpc = '0;
      if (reset) begin
        mode = M_RUNNING;
        exp_v = {7'b0, e_cause, e_cpc, target};
        target = '0; wake = '0;
      end else begin
        exp_v = '0;
        if (mode == M_RUNNING) begin
          e_ready = 1'b1;
          if (commit_valid && interrupted) begin
            e_ht = 1; e_fl = 1; e_cpc = commit_pc;
          end else if (commit_valid && commit_exc) begin
            e_ht = 1; e_exc = 1; e_fl = 1; e_cause = commit_cause; e_cpc = commit_pc;
          end else if (commit_valid && commit_mret) begin
            e_et = 1; e_ret = 1; e_fl = 1;
          end else if (commit_valid) begin
            e_ret = 1; e_fl = commit_wfi;
          end
        end else if (mode == M_TARGET) begin
          e_rv = 1; e_fl = 1;
        end else begin
          e_fl = 1;
          if (interrupted) begin e_ht = 1; e_cpc = wake; end
        end
        exp_v = {e_ready, e_ht, e_et, e_exc, e_fl, e_ret, e_rv, e_cause, e_cpc, target};
        // advance the model to the next cycle
        if (mode == M_RUNNING && commit_valid) begin
          if (interrupted || commit_exc) begin mode = M_TARGET; target = trap_pc; end
          else if (commit_mret) begin mode = M_TARGET; target = ret_pc; end
          else if (commit_wfi) begin mode = M_ASLEEP; wake = commit_pc + 32'd4; end
        end else if (mode == M_TARGET) begin
          if (redirect_ready) mode = M_RUNNING;
        end else if (mode == M_ASLEEP) begin
          if (interrupted) begin mode = M_TARGET; target = trap_pc; end
        end
      end
      got_v = {commit_ready, handle_trap, exit_trap, exception, flush, retired, redirect_valid,
               exception_cause, current_pc, redirect_pc};
      total++;
      if (got_v !== exp_v) begin
        bad++;
        $display("FAIL rand_cyc%0d: got %h want %h", cyc, got_v, exp_v);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive_idle();
    trap_pc = '0; ret_pc = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_exception();
    test_simultaneous();
    test_mret();
    test_wfi(32'h300, 32'h304);
    test_wfi(32'hFFFF_FFFC, 32'h0000_0000);
    test_irq_no_valid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have clk  in  1  clock; all state updates on its rising edge.
REQ-002 SHALL have reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have commit_valid  in  1  an instruction is presented at the commit stage.
REQ-004 SHALL have commit_ready  out  1  the controller accepts the commit-stage instruction this cycle.
REQ-005 SHALL have commit_pc  in  32  PC of the commit-stage instruction.
REQ-006 SHALL have commit_exc  in  1  the commit-stage instruction raised an exception.
REQ-007 SHALL have commit_cause  in  31  exception cause code.
REQ-008 SHALL have commit_mret / commit_wfi  in  1 each  the instruction is MRET / WFI.
REQ-009 SHALL have interrupted  in  1  enabled interrupt pending, from the CSR file.
REQ-010 SHALL have trap_pc / ret_pc  in  32 each  mtvec / mepc, from the CSR file.
REQ-011 SHALL have handle_trap, exit_trap, exception  out  1 each  CSR trap strobes.
REQ-012 SHALL have exception_cause  out  31 and current_pc  out  32  trap cause and saved PC to the CSR file.
REQ-013 SHALL have redirect_valid  out  1, redirect_ready  in  1, redirect_pc  out  32  fetch-redirect handshake.
REQ-014 SHALL have flush  out  1  kill all younger in-flight instructions.
REQ-015 SHALL have retired  out  1  one-cycle pulse per architecturally retired instruction.

Function
REQ-016 SHALL implement states RUN, REDIRECT, WFI.
REQ-017 In RUN, commit_ready SHALL be 1; in REDIRECT and WFI it SHALL be 0.
REQ-018 In RUN, event priority per cycle SHALL be: interrupted > commit_exc > commit_mret > commit_wfi > normal retire.
REQ-019 Interrupt in RUN with commit_valid=1: handle_trap=1, exception=0, current_pc=commit_pc, retired=0, flush=1; redirect_pc latched from trap_pc; next state REDIRECT.
REQ-020 Interrupt in RUN with commit_valid=0 SHALL NOT be taken; it is taken on the next cycle with commit_valid=1.
REQ-021 Exception (commit_valid & commit_exc, no interrupt): handle_trap=1, exception=1, exception_cause=commit_cause, current_pc=commit_pc, retired=0, flush=1; redirect_pc latched from trap_pc; next state REDIRECT.
REQ-022 MRET (valid, no interrupt/exc): exit_trap=1, retired=1, flush=1; redirect_pc latched from ret_pc; next state REDIRECT.
REQ-023 WFI (valid, no interrupt/exc/mret): retired=1, flush=1; commit_pc+4 (mod 2^32) latched as wake PC; next state WFI.
REQ-024 Normal (valid, no special condition): retired=1 in the same cycle; state remains RUN.
REQ-025 In REDIRECT, redirect_valid SHALL be 1 with redirect_pc held stable, and flush SHALL be 1; on redirect_ready=1 the state SHALL become RUN next cycle.
REQ-026 Interrupts and commit events arriving in REDIRECT SHALL be ignored; they are evaluated in RUN.
REQ-027 In WFI, flush SHALL be 1; on interrupted=1: handle_trap=1, exception=0, current_pc=wake PC; redirect_pc latched from trap_pc; next state REDIRECT.
REQ-028 handle_trap and exit_trap SHALL each be single-cycle pulses and SHALL never assert in the same cycle.
REQ-029 exception and exception_cause SHALL be 0 whenever handle_trap=0, and current_pc SHALL be 0 whenever handle_trap=0.
REQ-030 redirect_valid SHALL be 0 outside REDIRECT.
REQ-031 Minimum latency SHALL be: event at cycle T, redirect_valid at T+1, and with redirect_ready=1 at T+1, commit_ready=1 at T+2.

Reset
REQ-032 On reset: state=RUN, redirect_pc=0, wake PC=0; all strobes, flush, redirect_valid and retired=0; commit_ready=1 in the first cycle after reset.
REQ-033 Reset asserted in any state, including mid-REDIRECT or WFI, SHALL override all events; no strobe SHALL assert during reset.

Verification
REQ-034 Exception: commit_valid=1, commit_exc=1, cause=2, pc=0x100, trap_pc=0x80 -> handle_trap=1, exception=1, cause=2, current_pc=0x100; then redirect_valid=1, redirect_pc=0x80.
REQ-035 Simultaneous events: interrupted=1 and commit_exc=1, pc=0x200 -> exception=0, current_pc=0x200, retired=0.
REQ-036 MRET: ret_pc=0x204, redirect_ready held 0 for 3 cycles -> exit_trap pulses once, redirect_valid=1 for 4 cycles, redirect_pc=0x204, commit_ready=0 throughout.
REQ-037 WFI: commit_wfi at pc=0x300; interrupted=1 five cycles later -> handle_trap=1, current_pc=0x304; commit_ready=0 while waiting.
REQ-038 Wrap-around: WFI at pc=0xFFFFFFFC, then interrupt -> current_pc=0x00000000.
REQ-039 Reset mid-operation: reset during REDIRECT -> redirect_valid=0 next cycle, commit_ready=1 after reset deasserts.
